// File: rtl/bcd_countdown_timer.sv
// Loadable BCD countdown timer for an M:SS.t display.
// A four-state FSM (IDLE/RUN/PAUSE/DONE) gates the external tick strobe `en`.
// Each accepted tick removes one tenth of a second from the count.
// Reaching 0:00.0 enters DONE and raises `expired`.
module bcd_countdown_timer #(
  parameter int DONE_PULSE = 1
) (
  input  logic       clk,
  input  logic       r,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] set_q0,
  input  logic [7:0] set_qs,
  input  logic [3:0] set_qm,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] q0,
  output logic [7:0] qs,
  output logic [3:0] qm,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       exp_p;
  logic       count_zero;
  logic       last_tick;
  logic       tick;
  logic [3:0] dec_q0;
  logic [7:0] dec_qs;
  logic [3:0] dec_qm;

  // Clamp a preset digit to its largest legal BCD value.
  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  assign count_zero = (q0 == 4'd0) && (qs == 8'h00) && (qm == 4'd0);
  // A tick is taken only in RUN, and only when neither load nor pause outranks it.
  assign tick       = (state == RUN) && en && !load && !pause;
  // The tick that takes 0:00.1 down to 0:00.0 also moves the FSM into DONE.
  assign last_tick  = tick && (qm == 4'd0) && (qs == 8'h00) && (q0 == 4'd1);

  // Borrow chain: each digit wraps to its maximum and borrows from the next digit up.
  always_comb begin
    dec_q0 = q0;
    dec_qs = qs;
    dec_qm = qm;
    if (q0 != 4'd0) begin
      dec_q0 = q0 - 4'd1;
    end else begin
      dec_q0 = 4'd9;
      if (qs[3:0] != 4'd0) begin
        dec_qs[3:0] = qs[3:0] - 4'd1;
      end else begin
        dec_qs[3:0] = 4'd9;
        if (qs[7:4] != 4'd0) begin
          dec_qs[7:4] = qs[7:4] - 4'd1;
        end else begin
          dec_qs[7:4] = 4'd5;
          dec_qm      = qm - 4'd1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (r) state <= IDLE;
    else   state <= state_nxt;
  end

  // Next-state logic. Input priority is load > pause > start > en.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: if (!pause && start) state_nxt = count_zero ? DONE : RUN;
        RUN: begin
          if (pause)          state_nxt = PAUSE;
          else if (last_tick) state_nxt = DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Registered one-cycle flag: high during the first cycle spent in DONE.
  always_ff @(posedge clk) begin
    if (r) exp_p <= 1'b0;
    else   exp_p <= (state_nxt == DONE) && (state != DONE);
  end

  // Digit registers: saturating preset load, or one decrement per accepted tick.
  always_ff @(posedge clk) begin
    if (r) begin
      q0 <= 4'd0;
      qs <= 8'h00;
      qm <= 4'd0;
    end else if (load) begin
      q0 <= sat_digit(set_q0, 4'd9);
      qs <= {sat_digit(set_qs[7:4], 4'd5), sat_digit(set_qs[3:0], 4'd9)};
      qm <= sat_digit(set_qm, 4'd9);
    end else if (tick) begin
      q0 <= dec_q0;
      qs <= dec_qs;
      qm <= dec_qm;
    end
  end

  // Status outputs are decoded from registered state only.
  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
    expired = (DONE_PULSE != 0) ? exp_p : (state == DONE);
  end

endmodule
